// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the RV32IM hazard controller.
// Holds the forwarding-select codes, the MUL/DIV FSM states and a constant clog2.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } md_state_e;

  // Ceiling log2, evaluated at elaboration time to size counters.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_md_timer.sv
// MUL/DIV occupancy tracker: a RUN/MD_WAIT FSM plus a down-counter.
// busy covers every occupied cycle; freeze covers the cycles after the issue cycle.
module hazard_md_timer
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done,
  output logic freeze
);

  localparam int CNT_W    = (clog2(DIV_LAT) < 1) ? 1 : clog2(DIV_LAT);
  localparam int MUL_LOAD = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;
  localparam int DIV_LOAD = (DIV_LAT > 1) ? DIV_LAT - 2 : 0;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             multi_cycle;

  assign multi_cycle = is_div ? (DIV_LAT > 1) : (MUL_LAT > 1);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    freeze  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (start) begin
          busy = 1'b1;
          if (multi_cycle) begin
            state_d = ST_MD_WAIT;
            cnt_d   = is_div ? CNT_W'(DIV_LOAD) : CNT_W'(MUL_LOAD);
          end else begin
            done = 1'b1;
          end
        end
      end
      ST_MD_WAIT: begin
        // start is ignored here: EX is frozen and still presents the same op.
        busy   = 1'b1;
        freeze = 1'b1;
        if (cnt_q == '0) begin
          done    = 1'b1;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the RV32IM 5-stage pipeline: forwarding, load-use, MUL/DIV and flush.
// Define HAZARD_PERF_CNT_EN to build the STALL_CYCLES / FLUSH_COUNT counters (else tied to 0).
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_SRC*ADDR_W-1:0] ID_SRC_ADDR,
  input  logic [NUM_SRC-1:0]        ID_SRC_USED,
  input  logic [ADDR_W-1:0]         EX_RD,
  input  logic [ADDR_W-1:0]         MEM_RD,
  input  logic [ADDR_W-1:0]         WB_RD,
  input  logic                      EX_WE,
  input  logic                      MEM_WE,
  input  logic                      WB_WE,
  input  logic                      EX_MEMREAD,
  input  logic                      EX_MD_START,
  input  logic                      EX_IS_DIV,
  input  logic                      BRANCH_TAKEN,
  output logic [NUM_SRC*2-1:0]      FWD_SEL,
  output logic                      STALL,
  output logic                      BUBBLE,
  output logic                      FREEZE_EX,
  output logic                      FLUSH,
  output logic                      MD_BUSY,
  output logic                      MD_DONE,
  output logic [31:0]               STALL_CYCLES,
  output logic [31:0]               FLUSH_COUNT
);

  logic [NUM_SRC*2-1:0] fwd_sel;
  logic [NUM_SRC-1:0]   lu_hit;
  logic                 load_use;
  logic                 md_busy, md_done, md_freeze;
  logic                 stall, bubble, freeze_ex, flush;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
    logic [ADDR_W-1:0] src;
    logic              chk;
    fwd_sel_e          sel;

    // A zero source never forwards, so an x0 destination can never match either.
    assign src = ID_SRC_ADDR[gi*ADDR_W +: ADDR_W];
    assign chk = ID_SRC_USED[gi] && (src != '0);

    always_comb begin
      sel = FWD_RF;
      if (chk) begin
        if (EX_WE && (EX_RD == src))        sel = FWD_EX;
        else if (MEM_WE && (MEM_RD == src)) sel = FWD_MEM;
        else if (WB_WE && (WB_RD == src))   sel = FWD_WB;
      end
    end

    assign fwd_sel[gi*2 +: 2] = sel;
    assign lu_hit[gi]         = chk && (EX_RD == src);
  end

  assign load_use = EX_MEMREAD && EX_WE && (|lu_hit);

  hazard_md_timer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_timer (
    .clk    (CLK),
    .rst    (RESET),
    .start  (EX_MD_START),
    .is_div (EX_IS_DIV),
    .busy   (md_busy),
    .done   (md_done),
    .freeze (md_freeze)
  );

  // Priority: MUL/DIV wait > flush > load-use; an MD issue cycle masks load-use.
  always_comb begin
    stall     = 1'b0;
    bubble    = 1'b0;
    freeze_ex = 1'b0;
    flush     = 1'b0;
    if (md_freeze) begin
      stall     = 1'b1;
      freeze_ex = 1'b1;
    end else if (BRANCH_TAKEN) begin
      flush  = 1'b1;
      bubble = 1'b1;
    end else if (load_use && !EX_MD_START) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end
  end

  assign FWD_SEL   = RESET ? '0 : fwd_sel;
  assign STALL     = stall     && !RESET;
  assign BUBBLE    = bubble    && !RESET;
  assign FREEZE_EX = freeze_ex && !RESET;
  assign FLUSH     = flush     && !RESET;
  assign MD_BUSY   = md_busy   && !RESET;
  assign MD_DONE   = md_done   && !RESET;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Both counters saturate rather than wrap so long runs never read as short ones.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign STALL_CYCLES = stall_cnt_q;
  assign FLUSH_COUNT  = flush_cnt_q;
`else
  assign STALL_CYCLES = '0;
  assign FLUSH_COUNT  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios plus randomized traffic.
// Expected values come from a cycle-level occupancy model kept in the bench.
module tb_hazard_ctrl_unit;

  localparam int ADDR_W  = 5;
  localparam int NUM_SRC = 2;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 33;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_SRC*ADDR_W-1:0] id_src_addr;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [ADDR_W-1:0]         ex_rd, mem_rd, wb_rd;
  logic                      ex_we, mem_we, wb_we;
  logic                      ex_memread, ex_md_start, ex_is_div, branch_taken;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic                      stall, bubble, freeze_ex, flush, md_busy, md_done;
  logic [31:0]               stall_cycles, flush_count;

  hazard_ctrl_unit #(
    .ADDR_W  (ADDR_W),
    .NUM_SRC (NUM_SRC),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .CLK          (clk),
    .RESET        (rst),
    .ID_SRC_ADDR  (id_src_addr),
    .ID_SRC_USED  (id_src_used),
    .EX_RD        (ex_rd),
    .MEM_RD       (mem_rd),
    .WB_RD        (wb_rd),
    .EX_WE        (ex_we),
    .MEM_WE       (mem_we),
    .WB_WE        (wb_we),
    .EX_MEMREAD   (ex_memread),
    .EX_MD_START  (ex_md_start),
    .EX_IS_DIV    (ex_is_div),
    .BRANCH_TAKEN (branch_taken),
    .FWD_SEL      (fwd_sel),
    .STALL        (stall),
    .BUBBLE       (bubble),
    .FREEZE_EX    (freeze_ex),
    .FLUSH        (flush),
    .MD_BUSY      (md_busy),
    .MD_DONE      (md_done),
    .STALL_CYCLES (stall_cycles),
    .FLUSH_COUNT  (flush_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: cycles of occupancy still to come after the issue cycle.
  int          md_rem = 0;
  logic [31:0] exp_stall_cnt = '0;
  logic [31:0] exp_flush_cnt = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [ADDR_W-1:0] src, input logic used);
    if (!used || src == 0)          return 2'b00;
    if (ex_we && ex_rd == src)      return 2'b01;
    if (mem_we && mem_rd == src)    return 2'b10;
    if (wb_we && wb_rd == src)      return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic ref_load_use();
    logic hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      logic [ADDR_W-1:0] s = id_src_addr[i*ADDR_W +: ADDR_W];
      if (id_src_used[i] && s != 0 && s == ex_rd) hit = 1'b1;
    end
    return ex_memread && ex_we && hit;
  endfunction

  // Inputs are applied just after a rising edge; outputs are checked 2 ns later,
  // then the model advances across the next rising edge.
  task automatic run_cycle(input string tag);
    logic [NUM_SRC*2-1:0] e_fwd;
    logic e_stall, e_bubble, e_freeze, e_flush, e_busy, e_done;
    int   lat;
    e_fwd = '0; e_stall = 0; e_bubble = 0; e_freeze = 0;
    e_flush = 0; e_busy = 0; e_done = 0;
    lat = ex_is_div ? DIV_LAT : MUL_LAT;
    #2;
    if (!rst) begin
      for (int i = 0; i < NUM_SRC; i++)
        e_fwd[i*2 +: 2] = ref_fwd(id_src_addr[i*ADDR_W +: ADDR_W], id_src_used[i]);
      if (md_rem > 0) begin
        e_busy = 1; e_stall = 1; e_freeze = 1;
        e_done = (md_rem == 1);
      end else begin
        if (ex_md_start) begin
          e_busy = 1;
          e_done = (lat == 1);
        end
        if (branch_taken) begin
          e_flush = 1; e_bubble = 1;
        end else if (ref_load_use() && !ex_md_start) begin
          e_stall = 1; e_bubble = 1;
        end
      end
    end
    check({tag, ".fwd"},    32'(fwd_sel),   32'(e_fwd));
    check({tag, ".stall"},  32'(stall),     32'(e_stall));
    check({tag, ".bubble"}, 32'(bubble),    32'(e_bubble));
    check({tag, ".freeze"}, 32'(freeze_ex), 32'(e_freeze));
    check({tag, ".flush"},  32'(flush),     32'(e_flush));
    check({tag, ".busy"},   32'(md_busy),   32'(e_busy));
    check({tag, ".done"},   32'(md_done),   32'(e_done));
    check({tag, ".stall_cycles"}, stall_cycles, exp_stall_cnt);
    check({tag, ".flush_count"},  flush_count,  exp_flush_cnt);
    @(posedge clk);
    if (rst) begin
      md_rem        = 0;
      exp_stall_cnt = '0;
      exp_flush_cnt = '0;
    end else begin
`ifdef HAZARD_PERF_CNT_EN
      if (e_stall && exp_stall_cnt != '1) exp_stall_cnt++;
      if (e_flush && exp_flush_cnt != '1) exp_flush_cnt++;
`endif
      if (md_rem > 0)       md_rem--;
      else if (ex_md_start) md_rem = lat - 1;
    end
    #1;
  endtask

  task automatic clear_inputs();
    id_src_addr = '0; id_src_used = '0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_we = 0; mem_we = 0; wb_we = 0;
    ex_memread = 0; ex_md_start = 0; ex_is_div = 0; branch_taken = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    #1 rst = 1'b1;
    run_cycle("reset");
    run_cycle("reset");
    rst = 1'b0;
    run_cycle("idle");

    // Forwarding priority on operand 0 (x5).
    id_src_addr[0 +: ADDR_W] = 5'd5; id_src_used[0] = 1;
    ex_rd = 5'd5; ex_we = 1; mem_rd = 5'd5; mem_we = 1; wb_rd = 5'd5; wb_we = 1;
    run_cycle("fwd_ex");
    ex_we = 0;
    run_cycle("fwd_mem");
    mem_we = 0;
    run_cycle("fwd_wb");

    // Operand 1 reads x0 while EX writes x0: no forward, no stall.
    clear_inputs();
    id_src_addr[ADDR_W +: ADDR_W] = 5'd0; id_src_used[1] = 1;
    ex_rd = 5'd0; ex_we = 1; ex_memread = 1;
    run_cycle("x0");

    // Load-use on x7, then the load has moved to MEM.
    clear_inputs();
    id_src_addr[0 +: ADDR_W] = 5'd7; id_src_used[0] = 1;
    ex_rd = 5'd7; ex_we = 1; ex_memread = 1;
    run_cycle("load_use");
    ex_rd = 5'd0; ex_we = 0; ex_memread = 0; mem_rd = 5'd7; mem_we = 1;
    run_cycle("load_fwd");

    // Divide: the op stays presented in EX for its whole occupancy.
    clear_inputs();
    ex_md_start = 1; ex_is_div = 1;
    for (int c = 0; c < DIV_LAT; c++) run_cycle("div");
    clear_inputs();
    run_cycle("post_div");

    // Multiply.
    ex_md_start = 1; ex_is_div = 0;
    for (int c = 0; c < MUL_LAT; c++) run_cycle("mul");
    clear_inputs();
    run_cycle("post_mul");

    // Branch taken coincident with a load-use match.
    id_src_addr[0 +: ADDR_W] = 5'd9; id_src_used[0] = 1;
    ex_rd = 5'd9; ex_we = 1; ex_memread = 1; branch_taken = 1;
    run_cycle("flush");
    clear_inputs();
    run_cycle("post_flush");

    // Reset asserted in cycle 10 of a divide.
    ex_md_start = 1; ex_is_div = 1;
    for (int c = 0; c < 9; c++) run_cycle("div_pre_rst");
    rst = 1'b1;
    run_cycle("rst_mid");
    rst = 1'b0;
    clear_inputs();
    run_cycle("after_rst");
    ex_md_start = 1; ex_is_div = 0;
    for (int c = 0; c < MUL_LAT; c++) run_cycle("mul_after_rst");
    clear_inputs();

    // Randomized traffic over a small register range to provoke matches.
    for (int n = 0; n < 600; n++) begin
      id_src_addr  = NUM_SRC*ADDR_W'($urandom_range(0, 1023) & 10'h0E7);
      id_src_used  = NUM_SRC'($urandom);
      ex_rd        = ADDR_W'($urandom_range(0, 7));
      mem_rd       = ADDR_W'($urandom_range(0, 7));
      wb_rd        = ADDR_W'($urandom_range(0, 7));
      ex_we        = 1'($urandom);
      mem_we       = 1'($urandom);
      wb_we        = 1'($urandom);
      ex_memread   = 1'($urandom);
      ex_md_start  = ($urandom_range(0, 15) == 0);
      ex_is_div    = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      rst          = ($urandom_range(0, 149) == 0);
      run_cycle("rand");
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
